// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
// Pure package: no logic, no latency, no flow control.
package seq_det_pkg;

    typedef enum logic {
        NON_OVERLAP = 1'b0,
        OVERLAP     = 1'b1
    } mode_e;

    localparam int unsigned MASK_W = 32;

    function automatic int len_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    // Low `len` bits set; len >= MASK_W yields all ones so len == MAX_LEN compares everything.
    function automatic logic [MASK_W-1:0] mask_of(input int unsigned len);
        logic [MASK_W-1:0] m;
        if (len >= MASK_W) m = '1;
        else               m = (MASK_W'(1) << len) - MASK_W'(1);
        return m;
    endfunction

endpackage

// File: rtl/seq_detect_param_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// Latency: count updates one clock after inc/clr. No backpressure; holds at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seq_detect_param.sv
// Serial detector for a runtime-loaded 1..MAX_LEN bit pattern, overlap or non-overlap.
// Latency: detect registered one clock after the final pattern bit is sampled.
// Backpressure: en=0 stalls the stream; history and detect hold, nothing is lost.
module seq_detect_param
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 16,
    parameter int LEN_W   = len_width(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               d_in,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               detect,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cfg_valid
);

    localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] pattern_q;
    logic [LEN_W-1:0]   len_q;
    mode_e              mode_q;
    logic               cfg_valid_q;
    logic [MAX_LEN-1:0] hist_q;
    logic [LEN_W-1:0]   fill_q;
    logic               detect_q;

    logic [MAX_LEN-1:0] hist_n;
    logic [LEN_W-1:0]   fill_n;
    logic [MAX_LEN-1:0] mask;
    logic               match;

    always_comb begin
        hist_n = {hist_q[MAX_LEN-2:0], d_in};
        fill_n = (fill_q == FILL_MAX) ? fill_q : fill_q + LEN_W'(1);
        mask   = MAX_LEN'(mask_of(32'(len_q)));
        match  = 1'b0;
        if (en && !cfg_load && cfg_valid_q && (fill_n >= len_q)) begin
            match = (((hist_n ^ pattern_q) & mask) == '0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pattern_q   <= '0;
            len_q       <= '0;
            mode_q      <= NON_OVERLAP;
            cfg_valid_q <= 1'b0;
            hist_q      <= '0;
            fill_q      <= '0;
            detect_q    <= 1'b0;
        end else if (cfg_load) begin
            pattern_q   <= cfg_pattern;
            len_q       <= cfg_len;
            mode_q      <= mode_e'(cfg_overlap);
            cfg_valid_q <= (cfg_len != '0) && (cfg_len <= FILL_MAX);
            hist_q      <= '0;
            fill_q      <= '0;
            detect_q    <= 1'b0;
        end else if (en) begin
            hist_q   <= hist_n;
            detect_q <= match;
            // Non-overlap restarts the fill so the next hit needs len fresh bits.
            fill_q   <= (match && (mode_q == NON_OVERLAP)) ? '0 : fill_n;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk (clk),
        .rst (rst),
        .inc (match),
        .clr (cnt_clr),
        .cnt (match_cnt)
    );

    assign detect    = detect_q;
    assign cfg_valid = cfg_valid_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench for seq_detect_param: a bit-queue reference model predicts
// detect / match_cnt / cfg_valid per cycle; predictions are popped after each edge.
module tb_seq_detect_param;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 4;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               en = 1'b0;
    logic               d_in = 1'b0;
    logic               cfg_load = 1'b0;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0]   cfg_len = '0;
    logic               cfg_overlap = 1'b0;
    logic               cnt_clr = 1'b0;
    logic               detect;
    logic [CNT_W-1:0]   match_cnt;
    logic               cfg_valid;

    seq_detect_param #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .d_in        (d_in),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cnt_clr     (cnt_clr),
        .detect      (detect),
        .match_cnt   (match_cnt),
        .cfg_valid   (cfg_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    det;
        int    cnt;
        int    vld;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: bits received since the last load (or last non-overlap hit).
    int          m_bits[$];
    int unsigned m_pat;
    int          m_len;
    int          m_ovl;
    int          m_valid;
    int          m_det;
    int          m_cnt;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_pat = 0; m_len = 0; m_ovl = 0; m_valid = 0; m_det = 0; m_cnt = 0;
    endtask

    function automatic int model_match();
        int n;
        n = m_bits.size();
        if (!m_valid || n < m_len) return 0;
        for (int i = 0; i < m_len; i++)
            if (m_bits[n-1-i] != int'((m_pat >> i) & 1)) return 0;
        return 1;
    endfunction

    // Drive one cycle at the falling edge, predict, then compare after the rising edge.
    task automatic step(input string tag, input logic e, input logic d,
                        input logic ld, input logic cc);
        int   hit;
        exp_t x;
        exp_t y;
        @(negedge clk);
        en = e; d_in = d; cfg_load = ld; cnt_clr = cc;
        hit = 0;
        if (ld) begin
            m_pat   = int'(cfg_pattern);
            m_len   = int'(cfg_len);
            m_ovl   = int'(cfg_overlap);
            m_valid = (m_len >= 1 && m_len <= MAX_LEN) ? 1 : 0;
            m_bits.delete();
            m_det   = 0;
        end else if (e) begin
            m_bits.push_back(int'(d));
            if (m_bits.size() > 40) void'(m_bits.pop_front());
            hit   = model_match();
            m_det = hit;
            if (hit && !m_ovl) m_bits.delete();
        end
        if (cc)                         m_cnt = 0;
        else if (hit && m_cnt < CNT_MAX) m_cnt++;
        x.tag = tag; x.det = m_det; x.cnt = m_cnt; x.vld = m_valid;
        sb.push_back(x);
        @(posedge clk);
        #1;
        y = sb.pop_front();
        check({y.tag, ".detect"},    int'(detect),    y.det);
        check({y.tag, ".match_cnt"}, int'(match_cnt), y.cnt);
        check({y.tag, ".cfg_valid"}, int'(cfg_valid), y.vld);
        en = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic load(input string tag, input logic [MAX_LEN-1:0] p,
                        input int len, input logic ovl);
        cfg_pattern = p; cfg_len = LEN_W'(len); cfg_overlap = ovl;
        step(tag, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic stream(input string tag, input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) step(tag, 1'b1, bits[i], 1'b0, 1'b0);
    endtask

    initial begin
        model_reset();
        #12;
        check("reset.detect",    int'(detect),    0);
        check("reset.match_cnt", int'(match_cnt), 0);
        check("reset.cfg_valid", int'(cfg_valid), 0);
        @(negedge clk);
        rst = 1'b1;

        // Unconfigured: stream must not detect.
        stream("unconf", 32'b1011, 4);

        load("ovl_load", 8'b1011, 4, 1'b1);
        stream("ovl", 32'b1011011, 7);
        check("ovl.final_cnt", int'(match_cnt), 2);

        step("clr", 1'b0, 1'b0, 1'b0, 1'b1);
        load("novl_load", 8'b1011, 4, 1'b0);
        stream("novl", 32'b1011011, 7);
        check("novl.final_cnt", int'(match_cnt), 1);

        step("clr2", 1'b0, 1'b0, 1'b0, 1'b1);
        load("stall_load", 8'b111, 3, 1'b1);
        stream("stall_in", 32'b111, 3);
        for (int i = 0; i < 3; i++) step("stall_hold", 1'b0, 1'b1, 1'b0, 1'b0);
        stream("stall_drop", 32'b0, 1);
        check("stall.final_det", int'(detect), 0);

        // cfg_load beats en; its data bit is dropped.
        load("prio_load", 8'b1011, 4, 1'b1);
        stream("prio_pre", 32'b10, 2);
        step("prio_ld_en", 1'b1, 1'b1, 1'b1, 1'b0);
        stream("prio_part", 32'b011, 3);
        stream("prio_last", 32'b1, 1);
        stream("prio_more", 32'b01, 2);
        step("prio_clr_hit", 1'b1, 1'b1, 1'b0, 1'b1);
        check("prio.clr_wins", int'(match_cnt), 0);

        load("sat_load", 8'b1, 1, 1'b1);
        for (int i = 0; i < 20; i++) step("sat", 1'b1, 1'b1, 1'b0, 1'b0);
        check("sat.final_cnt", int'(match_cnt), CNT_MAX);
        stream("len1_zero", 32'b0, 1);

        step("clr3", 1'b0, 1'b0, 1'b0, 1'b1);
        load("full_load", 8'hA5, 8, 1'b1);
        stream("full", 32'h5A5A5, 20);

        load("len0_load", 8'hFF, 0, 1'b1);
        stream("len0", 32'hFFFF, 16);
        load("len9_load", 8'hFF, 9, 1'b1);
        stream("len9", 32'h0FF3, 16);
        for (int i = 0; i < 12; i++) begin
            logic b;
            b = 1'($urandom_range(0, 1));
            step("len9_rand", 1'b1, b, 1'b0, 1'b0);
        end

        load("rand_load", 8'b0110, 3, 1'b0);
        for (int i = 0; i < 40; i++) begin
            logic b;
            logic e;
            b = 1'($urandom_range(0, 1));
            e = ($urandom_range(0, 3) != 0);
            step("rand", e, b, 1'b0, 1'b0);
        end

        step("clr4", 1'b0, 1'b0, 1'b0, 1'b1);
        load("arst_load", 8'b1011, 4, 1'b1);
        stream("arst_pre", 32'b1011, 4);
        stream("arst_part", 32'b101, 3);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("arst.detect",    int'(detect),    0);
        check("arst.match_cnt", int'(match_cnt), 0);
        check("arst.cfg_valid", int'(cfg_valid), 0);
        @(negedge clk);
        rst = 1'b1;
        load("arst_reload", 8'b1011, 4, 1'b1);
        stream("arst_one", 32'b1, 1);
        stream("arst_rest", 32'b011, 3);
        check("arst.final_det", int'(detect), 1);

        check("sb.drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
